// File: rtl/merge_aw_arb_pkg.sv
// Shared types and defaults for the AW/W merge arbiter.
package merge_aw_arb_pkg;

    localparam int PAWUSER_WIDTH  = 4;
    localparam int ORD_DEPTH_DEF  = 4;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic {SRC_REG = 1'b0, SRC_MERGE = 1'b1} arb_src_t;
    typedef enum logic {ARB = 1'b0, HOLD = 1'b1} aw_state_t;

    // Fixed-priority ladder: starvation relief, then merge priority, then round-robin.
    function automatic arb_src_t pick_winner(input logic starved, input logic pri,
                                             input logic v0, input logic v1,
                                             input arb_src_t rr_last);
        if (starved && v0) return SRC_REG;
        if (pri && v1)     return SRC_MERGE;
        if (v0 && v1)      return (rr_last == SRC_REG) ? SRC_MERGE : SRC_REG;
        return v1 ? SRC_MERGE : SRC_REG;
    endfunction

endpackage

// File: rtl/merge_aw_arb_if.sv
// AXI AW/W write-request port; master drives requests, slave returns readies.
interface merge_aw_if import merge_aw_arb_pkg::*; #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = PAWUSER_WIDTH
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [USER_WIDTH-1:0] awuser;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;

    modport master (output awvalid, awid, awaddr, awlen, awuser, wvalid, wdata, wlast,
                    input  awready, wready);
    modport slave  (input  awvalid, awid, awaddr, awlen, awuser, wvalid, wdata, wlast,
                    output awready, wready);
endinterface

// File: rtl/merge_aw_arb_ord_fifo.sv
// 1-bit order FIFO holding the source of each granted AW; wrap bit separates full from empty.
module merge_ord_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_head  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wr[AW-1:0]] <= i_din;
                r_wr                <= r_wr + 1'b1;
            end
            if (i_pop && !o_empty)
                r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/merge_aw_arb.sv
// Shares one downstream AW/W port between the regular path (s0) and merge path (s1);
// W beats follow AW grant order through a small order FIFO.
module merge_aw_arb import merge_aw_arb_pkg::*; #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = PAWUSER_WIDTH,
    parameter int ORD_DEPTH  = ORD_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pri_merge,
    merge_aw_if.slave    s0,
    merge_aw_if.slave    s1,
    merge_aw_if.master   m,
    output logic         ord_full,
    output logic         ord_empty
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    aw_state_t        r_state, w_state_nxt;
    arb_src_t         r_hold_src, r_rr_last, w_sel, w_head;
    logic [CNT_W-1:0] r_starve;
    logic             r_blank;
    logic             w_en, w_full, w_empty, w_head_bit;
    logic             w_aw_vld, w_aw_hs;
    logic             w_w_act, w_head_wv, w_wlast, w_pop;

    // Outputs stay quiet for the reset cycle and the one after it.
    always_ff @(posedge clk) r_blank <= rst;
    assign w_en = ~rst & ~r_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_hold_src <= SRC_REG;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB && w_aw_vld && !m.awready)
                r_hold_src <= w_sel;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_aw_vld && !m.awready) w_state_nxt = HOLD;
            HOLD:    if (w_aw_hs)                w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        w_sel = (r_state == HOLD) ? r_hold_src
              : pick_winner(r_starve == CNT_W'(STARVE_MAX), pri_merge,
                            s0.awvalid, s1.awvalid, r_rr_last);
        w_aw_vld   = w_en & ~w_full & ((w_sel == SRC_MERGE) ? s1.awvalid : s0.awvalid);
        m.awvalid  = w_aw_vld;
        s0.awready = w_aw_vld & m.awready & (w_sel == SRC_REG);
        s1.awready = w_aw_vld & m.awready & (w_sel == SRC_MERGE);
    end

    assign w_aw_hs  = w_aw_vld & m.awready;
    assign m.awid   = (w_sel == SRC_MERGE) ? s1.awid   : s0.awid;
    assign m.awaddr = (w_sel == SRC_MERGE) ? s1.awaddr : s0.awaddr;
    assign m.awlen  = (w_sel == SRC_MERGE) ? s1.awlen  : s0.awlen;
    assign m.awuser = (w_sel == SRC_MERGE) ? s1.awuser : s0.awuser;

    always_ff @(posedge clk) begin
        if (rst)          r_rr_last <= SRC_MERGE;
        else if (w_aw_hs) r_rr_last <= w_sel;
    end

    // A source-0 request that is the current grant neither ages nor clears until it handshakes.
    always_ff @(posedge clk) begin
        if (rst || !w_en || !s0.awvalid)
            r_starve <= '0;
        else if (w_aw_vld && w_sel == SRC_REG) begin
            if (m.awready) r_starve <= '0;
        end else if (r_starve != CNT_W'(STARVE_MAX))
            r_starve <= r_starve + CNT_W'(1);
    end

    merge_ord_fifo #(.DEPTH(ORD_DEPTH)) u_ord (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_aw_hs),
        .i_din   (1'(w_sel)),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head_bit)
    );

    assign w_head     = arb_src_t'(w_head_bit);
    assign w_w_act    = w_en & ~w_empty;
    assign w_head_wv  = (w_head == SRC_MERGE) ? s1.wvalid : s0.wvalid;
    assign w_wlast    = (w_head == SRC_MERGE) ? s1.wlast  : s0.wlast;
    assign m.wvalid   = w_w_act & w_head_wv;
    assign m.wdata    = (w_head == SRC_MERGE) ? s1.wdata  : s0.wdata;
    assign m.wlast    = w_wlast;
    assign s0.wready  = w_w_act & m.wready & (w_head == SRC_REG);
    assign s1.wready  = w_w_act & m.wready & (w_head == SRC_MERGE);
    assign w_pop      = w_w_act & w_head_wv & m.wready & w_wlast;

    assign ord_full  = w_full & ~rst;
    assign ord_empty = w_empty | rst;
endmodule
